// File: rtl/simt_scheduler.sv
// simt_scheduler: per-core control FSM for one block of SIMT threads.
// Each lane keeps its own PC; instructions issue to lanes at the minimum live PC.
module simt_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int COUNT_BITS        = 16,
    localparam int TCW              = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [TCW-1:0]                             thread_count,
    input  logic [2:0]                                 fetcher_state,
    input  logic                                       decoded_mem_read_enable,
    input  logic                                       decoded_mem_write_enable,
    input  logic                                       decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0][1:0]          lsu_state,
    input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]  next_pc,
    output logic [2:0]                                 core_state,
    output logic [PC_BITS-1:0]                         current_pc,
    output logic [THREADS_PER_BLOCK-1:0]               active_mask,
    output logic                                       done,
    output logic [COUNT_BITS-1:0]                      instr_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [2:0] FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQ = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;

    state_t                                     state;
    logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]  thread_pc;
    logic [THREADS_PER_BLOCK-1:0]               retired;
    logic [THREADS_PER_BLOCK-1:0]               live;
    logic [THREADS_PER_BLOCK-1:0]               retired_after;
    logic [THREADS_PER_BLOCK-1:0]               launch_retired;
    logic [PC_BITS-1:0]                         min_pc;
    logic                                       found;
    logic                                       lsu_busy;
    logic                                       unused_mem;

    // Memory-op flags are informational; per-lane LSU states alone gate WAIT.
    assign unused_mem = decoded_mem_read_enable ^ decoded_mem_write_enable;

    assign core_state = state;
    assign live       = ~retired;
    assign current_pc = min_pc;

    // Minimum PC over live lanes (unsigned); zero when every lane is retired.
    always_comb begin
        min_pc = '0;
        found  = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (live[i] && (!found || thread_pc[i] < min_pc)) begin
                min_pc = thread_pc[i];
                found  = 1'b1;
            end
        end
    end

    // Lanes sitting at the reconvergence PC execute this instruction.
    always_comb begin
        active_mask = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            active_mask[i] = live[i] && (thread_pc[i] == min_pc);
        end
    end

    // Only active lanes with an outstanding request can hold the FSM in WAIT.
    always_comb begin
        lsu_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (active_mask[i] &&
                (lsu_state[i] == LSU_REQ || lsu_state[i] == LSU_WAIT)) begin
                lsu_busy = 1'b1;
            end
        end
    end

    // Retire set after a RET commits, and the lane-enable pattern at launch.
    always_comb begin
        retired_after = retired | (decoded_ret ? active_mask : '0);
        launch_retired = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            launch_retired[i] = (TCW'(i) >= thread_count);
        end
    end

    // Control FSM together with the per-lane PC / retire state and counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            thread_pc   <= '0;
            retired     <= '1;
            instr_count <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        thread_pc   <= '0;
                        retired     <= launch_retired;
                        instr_count <= '0;
                        if (thread_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fetcher_state == FETCHED) begin
                        state <= DECODE;
                    end
                end
                DECODE:  state <= REQUEST;
                REQUEST: state <= WAIT;
                WAIT: begin
                    if (!lsu_busy) begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: state <= UPDATE;
                UPDATE: begin
                    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
                        if (active_mask[i] && !decoded_ret) begin
                            thread_pc[i] <= next_pc[i];
                        end
                    end
                    retired <= retired_after;
                    if (instr_count != '1) begin
                        instr_count <= instr_count + COUNT_BITS'(1);
                    end
                    if (&retired_after) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simt_scheduler.sv
// tb_simt_scheduler: directed self-checking bench for simt_scheduler.
// A second instance with a 2-bit counter shares stimulus to cover saturation.
module tb_simt_scheduler;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       thread_count;
    logic [2:0]       fetcher_state;
    logic             decoded_mem_read_enable;
    logic             decoded_mem_write_enable;
    logic             decoded_ret;
    logic [3:0][1:0]  lsu_state;
    logic [3:0][7:0]  next_pc;

    logic [2:0]       core_state;
    logic [7:0]       current_pc;
    logic [3:0]       active_mask;
    logic             done;
    logic [15:0]      instr_count;

    logic [2:0]       core_state2;
    logic [7:0]       current_pc2;
    logic [3:0]       active_mask2;
    logic             done2;
    logic [1:0]       instr_count2;

    int checks = 0;
    int failures = 0;

    simt_scheduler #(
        .THREADS_PER_BLOCK(4), .PC_BITS(8), .COUNT_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .thread_count(thread_count), .fetcher_state(fetcher_state),
        .decoded_mem_read_enable(decoded_mem_read_enable),
        .decoded_mem_write_enable(decoded_mem_write_enable),
        .decoded_ret(decoded_ret), .lsu_state(lsu_state),
        .next_pc(next_pc), .core_state(core_state),
        .current_pc(current_pc), .active_mask(active_mask),
        .done(done), .instr_count(instr_count)
    );

    simt_scheduler #(
        .THREADS_PER_BLOCK(4), .PC_BITS(8), .COUNT_BITS(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start),
        .thread_count(thread_count), .fetcher_state(fetcher_state),
        .decoded_mem_read_enable(decoded_mem_read_enable),
        .decoded_mem_write_enable(decoded_mem_write_enable),
        .decoded_ret(decoded_ret), .lsu_state(lsu_state),
        .next_pc(next_pc), .core_state(core_state2),
        .current_pc(current_pc2), .active_mask(active_mask2),
        .done(done2), .instr_count(instr_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction from FETCH through UPDATE, with no memory stall.
    task automatic run_instr(input string tag, input logic [7:0] epc,
                             input logic [3:0] emask, input logic ret,
                             input logic [3:0][7:0] npc,
                             input logic [2:0] eend);
        int cyc;
        chk({tag, "_st"}, core_state, 3'd1);
        chk({tag, "_pc"}, current_pc, epc);
        chk({tag, "_mask"}, active_mask, emask);
        fetcher_state = 3'b010;
        decoded_ret = ret;
        next_pc = npc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            fetcher_state = 3'b000;
            if (core_state == 3'd6) chk({tag, "_umask"}, active_mask, emask);
        end while (core_state != 3'd1 && core_state != 3'd7 && cyc < 20);
        chk({tag, "_lat"}, cyc, 6);
        chk({tag, "_end"}, core_state, eend);
        decoded_ret = 1'b0;
    endtask

    task automatic launch(input logic [2:0] tc);
        thread_count = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        thread_count = 3'd0;
        fetcher_state = 3'd0;
        decoded_mem_read_enable = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_ret = 1'b0;
        lsu_state = '0;
        next_pc = '0;
        repeat (2) @(negedge clk);

        chk("rst_state", core_state, 3'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", instr_count, 16'd0);
        chk("rst_pc", current_pc, 8'd0);
        chk("rst_mask", active_mask, 4'b0000);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_hold", core_state, 3'd0);

        // Converged lanes, RET at pc 3.
        launch(3'd4);
        run_instr("conv0", 8'd0, 4'b1111, 1'b0, {4{8'd1}}, 3'd1);
        run_instr("conv1", 8'd1, 4'b1111, 1'b0, {4{8'd2}}, 3'd1);
        run_instr("conv2", 8'd2, 4'b1111, 1'b0, {4{8'd3}}, 3'd1);
        chk("conv_notdone", done, 1'b0);
        run_instr("conv3", 8'd3, 4'b1111, 1'b1, {4{8'hEE}}, 3'd7);
        chk("conv_done", done, 1'b1);
        chk("conv_count", instr_count, 16'd4);
        chk("conv_sat_count", instr_count2, 2'd3);
        chk("conv_done_mask", active_mask, 4'b0000);
        @(negedge clk);
        chk("conv_idle", core_state, 3'd0);
        chk("conv_idle_done", done, 1'b0);

        // Divergence at pc 2, reconvergence at pc 5; six instructions.
        launch(3'd4);
        run_instr("div0", 8'd0, 4'b1111, 1'b0, {4{8'd1}}, 3'd1);
        run_instr("div1", 8'd1, 4'b1111, 1'b0, {4{8'd2}}, 3'd1);
        run_instr("div2", 8'd2, 4'b1111, 1'b0,
                  {8'd3, 8'd3, 8'd5, 8'd5}, 3'd1);
        run_instr("div3", 8'd3, 4'b1100, 1'b0,
                  {8'd4, 8'd4, 8'hEE, 8'hEE}, 3'd1);
        run_instr("div4", 8'd4, 4'b1100, 1'b0,
                  {8'd5, 8'd5, 8'hEE, 8'hEE}, 3'd1);
        run_instr("div5", 8'd5, 4'b1111, 1'b1, {4{8'hEE}}, 3'd7);
        chk("div_count", instr_count, 16'd6);
        chk("div_sat_count", instr_count2, 2'd3);
        @(negedge clk);
        chk("div_idle", core_state, 3'd0);

        // Three lanes enabled; lane 1 retires early.
        launch(3'd3);
        run_instr("prt0", 8'd0, 4'b0111, 1'b0,
                  {8'hEE, 8'd4, 8'd1, 8'd4}, 3'd1);
        run_instr("prt1", 8'd1, 4'b0010, 1'b1, {4{8'hEE}}, 3'd1);
        run_instr("prt4", 8'd4, 4'b0101, 1'b0,
                  {8'hEE, 8'd5, 8'hEE, 8'd5}, 3'd1);
        chk("prt_notdone", done, 1'b0);
        run_instr("prt5", 8'd5, 4'b0101, 1'b1, {4{8'hEE}}, 3'd7);
        chk("prt_count", instr_count, 16'd4);
        @(negedge clk);
        chk("prt_idle", core_state, 3'd0);

        // Zero threads: straight to DONE; held start keeps DONE.
        thread_count = 3'd0;
        start = 1'b1;
        @(negedge clk);
        chk("zero_state", core_state, 3'd7);
        chk("zero_done", done, 1'b1);
        chk("zero_count", instr_count, 16'd0);
        @(negedge clk);
        chk("zero_hold", core_state, 3'd7);
        start = 1'b0;
        @(negedge clk);
        chk("zero_idle", core_state, 3'd0);
        chk("zero_idle_done", done, 1'b0);

        // Memory wait on lane 0; inactive lanes stuck in REQUESTING.
        launch(3'd2);
        chk("mem_st", core_state, 3'd1);
        chk("mem_mask", active_mask, 4'b0011);
        lsu_state[3] = 2'd1;
        fetcher_state = 3'b010;
        decoded_mem_read_enable = 1'b1;
        next_pc = {8'd0, 8'd0, 8'd2, 8'd1};
        @(negedge clk);
        fetcher_state = 3'b000;
        chk("mem_decode", core_state, 3'd2);
        @(negedge clk);
        chk("mem_request", core_state, 3'd3);
        lsu_state[0] = 2'd2;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("mem_hold%0d", k), core_state, 3'd4);
            if (k < 4) @(negedge clk);
        end
        lsu_state[0] = 2'd3;
        @(negedge clk);
        chk("mem_exec", core_state, 3'd5);
        lsu_state[0] = 2'd0;
        @(negedge clk);
        chk("mem_update", core_state, 3'd6);
        @(negedge clk);
        decoded_mem_read_enable = 1'b0;
        lsu_state[1] = 2'd1;
        run_instr("mem_r0", 8'd1, 4'b0001, 1'b1, {4{8'hEE}}, 3'd1);
        lsu_state[1] = 2'd0;
        run_instr("mem_r1", 8'd2, 4'b0010, 1'b1, {4{8'hEE}}, 3'd7);
        chk("mem_count", instr_count, 16'd3);
        lsu_state = '0;
        @(negedge clk);
        chk("mem_idle", core_state, 3'd0);

        // Asynchronous reset while in WAIT.
        launch(3'd4);
        run_instr("rw0", 8'd0, 4'b1111, 1'b0, {4{8'd1}}, 3'd1);
        fetcher_state = 3'b010;
        @(negedge clk);
        fetcher_state = 3'b000;
        @(negedge clk);
        lsu_state[0] = 2'd2;
        @(negedge clk);
        chk("rw_wait", core_state, 3'd4);
        chk("rw_count1", instr_count, 16'd1);
        reset = 1'b0;
        #1;
        chk("rw_state", core_state, 3'd0);
        chk("rw_done", done, 1'b0);
        chk("rw_count", instr_count, 16'd0);
        chk("rw_sat_count", instr_count2, 2'd0);
        chk("rw_pc", current_pc, 8'd0);
        chk("rw_mask", active_mask, 4'b0000);
        lsu_state = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rw_idle", core_state, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simt_scheduler.md
Name: simt_scheduler

Overview:
- Per-core control FSM that sequences fetch, decode, request, wait, execute and update for one block of threads.
- Tracks a private PC and retired flag per thread, so threads in a block may diverge on branches.
- Each instruction issues to the threads whose PC equals the minimum live PC (min-PC reconvergence).
- Sits between the fetcher/decoder/LSUs/PC units and replaces the single-PC scheduler; adds an active-mask output and an issued-instruction counter.

Parameters:
- THREADS_PER_BLOCK, 4, number of thread lanes (>=1).
- PC_BITS, 8, program counter width.
- COUNT_BITS, 16, width of the issued-instruction counter.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset; low forces the reset state immediately.
- start, input, 1, level; launches the block from IDLE.
- thread_count, input, $clog2(THREADS_PER_BLOCK)+1, number of enabled lanes; sampled in IDLE when start is high.
- fetcher_state, input, 3, fetcher state; 3'b010 = FETCHED.
- decoded_mem_read_enable, input, 1, current instruction reads memory.
- decoded_mem_write_enable, input, 1, current instruction writes memory.
- decoded_ret, input, 1, current instruction is RET.
- lsu_state, input, THREADS_PER_BLOCK x 2, per-lane LSU state: 0 IDLE, 1 REQUESTING, 2 WAITING, 3 DONE.
- next_pc, input, THREADS_PER_BLOCK x PC_BITS, per-lane next PC from the PC units.
- core_state, output, 3, FSM state.
- current_pc, output, PC_BITS, PC being fetched/executed.
- active_mask, output, THREADS_PER_BLOCK, lanes executing the current instruction.
- done, output, 1, high in DONE.
- instr_count, output, COUNT_BITS, instructions issued since start.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- Reset (reset low): core_state=IDLE, every thread_pc=0, every retired=1, instr_count=0, done=0. Reset mid-operation abandons the block; no partial update is committed.
- Live lane: enabled and not retired.
- current_pc: combinational minimum of thread_pc over live lanes; 0 if no lane is live.
- active_mask[i]: combinational; 1 iff lane i is live and thread_pc[i]==current_pc. Ties activate every matching lane.
- Both outputs change only after an UPDATE or start edge, so they are stable from FETCH through UPDATE.
- IDLE + start: clear all thread_pc to 0; set retired[i]=(i>=thread_count); clear instr_count.
  - thread_count==0: go to DONE.
  - Otherwise: go to FETCH.
- FETCH: stay until fetcher_state==FETCHED, then go to DECODE.
- DECODE: unconditionally go to REQUEST (1 cycle).
- REQUEST: unconditionally go to WAIT (1 cycle).
- WAIT: go to EXECUTE when no active lane has lsu_state 1 or 2.
  - Non-memory instructions therefore spend exactly 1 cycle in WAIT.
  - Inactive lanes' LSU states are ignored.
- EXECUTE: unconditionally go to UPDATE (1 cycle).
- UPDATE, for active lanes only:
  - decoded_ret=1: set retired[i].
  - decoded_ret=0: thread_pc[i] <= next_pc[i].
  - Inactive lanes are untouched.
  - instr_count increments by 1 and saturates at all-ones.
  - Next state: DONE if all lanes are retired after this update, else FETCH.
- DONE: done=1. When start goes low, return to IDLE and clear done.
- A new start pulse is required to relaunch the block. start held high in DONE keeps the FSM in DONE.
- PC arithmetic is owned by the PC units. next_pc is accepted as-is, wrap-around included; the min-PC compare is unsigned.
- Best-case issue latency (1-cycle fetch, no memory access): 6 cycles per instruction (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).

Test Plan:
- Converged lanes: thread_count=4, next_pc=pc+1 for all lanes, RET at pc 3 -> active_mask=4'b1111 throughout; current_pc 0,1,2,3; done after the 4th UPDATE; instr_count=4.
- Divergence: at pc 2, lanes 0-1 get next_pc=5 and lanes 2-3 get next_pc=3 -> active_mask=4'b1100 at pc 3 and 4. When lanes 2-3 reach pc 5, active_mask=4'b1111 (reconverged).
- Partial RET plus disabled lanes: thread_count=3, lane 1 branches to a RET first -> lane 1 retires; lanes 0 and 2 continue; active_mask never includes lane 3; done only after all three retire.
- thread_count=0: start -> DONE on the next edge, instr_count=0. Dropping start returns to IDLE.
- Memory wait: LDR with lane 0 in lsu_state WAITING for 5 cycles -> FSM holds in WAIT exactly until lane 0 reports DONE. An inactive lane stuck in REQUESTING does not stall WAIT.
- Reset and saturation:
  - Assert reset low while in WAIT -> immediately IDLE, done=0, instr_count=0.
  - With COUNT_BITS=2, run 6 instructions -> instr_count holds at 3.
